// File: rtl/axi4_lite_pkg.sv
// Response codes and small helpers shared by the AXI4-Lite slave and master.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic [1:0] resp_for(input logic in_range);
      return in_range ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// NUM_REGS x DATA_WIDTH register storage: one byte-enabled write port, one combinational read port.
// Writes land on the rising edge; the read port always reflects the pre-edge contents.
module axi4_lite_regfile #(
   parameter int NUM_REGS   = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        we_i,
   input  logic [$clog2(NUM_REGS)-1:0] widx_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   input  logic [DATA_WIDTH/8-1:0]     wstrb_i,
   input  logic [$clog2(NUM_REGS)-1:0] ridx_i,
   output logic [DATA_WIDTH-1:0]       rdata_o
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb_i[b]) begin
               regs_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register slave: AW/W held independently, commit one edge after both are held; read data registered on AR.
// Backpressure: AW/W readies drop while held or while B is pending; ARREADY drops while R is pending.
module axi4_lite_slave
   import axi4_lite_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGS      = 4
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [ADDRESS_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDRESS_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * 4);

   logic                     aw_held_q, aw_held_d;
   logic [ADDRESS_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                     w_held_q,  w_held_d;
   logic [DATA_WIDTH-1:0]    w_data_q,  w_data_d;
   logic [DATA_WIDTH/8-1:0]  w_strb_q,  w_strb_d;
   logic                     bvalid_q,  bvalid_d;
   logic [1:0]               bresp_q,   bresp_d;
   logic                     rvalid_q,  rvalid_d;
   logic [DATA_WIDTH-1:0]    rdata_q,   rdata_d;
   logic [1:0]               rresp_q,   rresp_d;

   logic                     aw_hs, w_hs, ar_hs, commit, aw_in_range, ar_in_range;
   logic [DATA_WIDTH-1:0]    rf_rdata;

   assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
   assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
   assign S_AXI_ARREADY = !rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

   assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
   assign commit      = aw_held_q && w_held_q;
   assign aw_in_range = aw_addr_q < ADDR_LIMIT;
   assign ar_in_range = S_AXI_ARADDR < ADDR_LIMIT;

   // Out-of-range writes alias onto a valid index, so the write enable must gate on range.
   axi4_lite_regfile #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clk_i   (ACLK),
      .rst_ni  (ARESETN),
      .we_i    (commit && aw_in_range),
      .widx_i  (aw_addr_q[2 +: IDX_W]),
      .wdata_i (w_data_q),
      .wstrb_i (w_strb_q),
      .ridx_i  (S_AXI_ARADDR[2 +: IDX_W]),
      .rdata_o (rf_rdata)
   );

   always_comb begin
      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = S_AXI_AWADDR;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = resp_for(aw_in_range);
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      // rf_rdata is the pre-edge value, so a same-edge commit is not visible to this read.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = ar_in_range ? rf_rdata : '0;
         rresp_d  = resp_for(ar_in_range);
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave (NUM_REGS=4): each scenario task drives stimulus and checks inline.
module tb_axi4_lite_slave;

   logic        ACLK;
   logic        ARESETN;
   logic [31:0] S_AXI_AWADDR;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [31:0] S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;

   int errors = 0;
   int checks = 0;

   axi4_lite_slave #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .NUM_REGS      (4)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Full write: AW and W offered together, B collected; reports response and whether a bound expired.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output bit timed_out);
      bit aw_done = 0, w_done = 0, aw_acc, w_acc;
      int n = 0;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA  = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
         w_acc  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (aw_acc) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
         if (w_acc)  begin w_done  = 1; S_AXI_WVALID  = 1'b0; end
         n++;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n = 0;
      while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
      timed_out = !S_AXI_BVALID;
      resp = S_AXI_BRESP;
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output bit timed_out);
      int n = 0;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
      while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
      tick();
      S_AXI_ARVALID = 1'b0;
      timed_out = !S_AXI_RVALID;
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; bit to;
      ARESETN = 1'b0;
      #12;
      checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", S_AXI_BVALID); end
      checks++; if (S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", S_AXI_RVALID); end
      checks++; if (S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b want 00", S_AXI_BRESP); end
      checks++; if (S_AXI_RRESP !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b want 00", S_AXI_RRESP); end
      checks++; if (S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", S_AXI_RDATA); end
      @(negedge ACLK);
      ARESETN = 1'b1;
      tick();
      checks++; if (S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL rst_awready: got %b want 1", S_AXI_AWREADY); end
      checks++; if (S_AXI_WREADY !== 1'b1) begin errors++; $display("FAIL rst_wready: got %b want 1", S_AXI_WREADY); end
      checks++; if (S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_arready: got %b want 1", S_AXI_ARREADY); end
      do_read(32'h4, d, r, to);
      checks++; if (to || d !== 32'h0) begin errors++; $display("FAIL rst_reg1: got %h want 00000000 (timeout=%0b)", d, to); end
   endtask

   task automatic test_same_cycle_write();
      logic [31:0] d; logic [1:0] r; bit to;
      S_AXI_AWADDR = 32'h4; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      checks++; if (!(S_AXI_AWREADY && S_AXI_WREADY)) begin errors++; $display("FAIL s1_ready: got aw=%b w=%b want 1 1", S_AXI_AWREADY, S_AXI_WREADY); end
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL s1_bvalid_early: got %b want 0", S_AXI_BVALID); end
      checks++; if (S_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL s1_awready_held: got %b want 0", S_AXI_AWREADY); end
      tick();
      checks++; if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL s1_bvalid: got %b want 1", S_AXI_BVALID); end
      checks++; if (S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL s1_bresp: got %b want 00", S_AXI_BRESP); end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL s1_bvalid_clr: got %b want 0", S_AXI_BVALID); end
      do_read(32'h4, d, r, to);
      checks++; if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin errors++; $display("FAIL s1_read: got %h/%b want deadbeef/00 (timeout=%0b)", d, r, to); end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d; logic [1:0] r; bit to;
      do_write(32'h8, 32'h11223344, 4'hF, r, to);
      checks++; if (to || r !== 2'b00) begin errors++; $display("FAIL s2_pre_bresp: got %b want 00 (timeout=%0b)", r, to); end
      S_AXI_WDATA = 32'h000000AA; S_AXI_WSTRB = 4'h1; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
            errors++; $display("FAIL s2_wait%0d: got w=%b aw=%b b=%b want 0 1 0", i, S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID); end
         tick();
      end
      S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      checks++; if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
         errors++; $display("FAIL s2_held: got aw=%b w=%b b=%b want 0 0 0", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID); end
      tick();
      checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL s2_b: got %b/%b want 1/00", S_AXI_BVALID, S_AXI_BRESP); end
      tick();
      checks++; if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin errors++; $display("FAIL s2_ready_during_b: got aw=%b w=%b want 0 0", S_AXI_AWREADY, S_AXI_WREADY); end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      checks++; if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin errors++; $display("FAIL s2_ready_after_b: got aw=%b w=%b want 1 1", S_AXI_AWREADY, S_AXI_WREADY); end
      do_read(32'h8, d, r, to);
      checks++; if (to || d !== 32'h112233AA || r !== 2'b00) begin errors++; $display("FAIL s2_read: got %h/%b want 112233aa/00 (timeout=%0b)", d, r, to); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; logic [1:0] r; bit to;
      do_write(32'h0, 32'h00000001, 4'hF, r, to);
      checks++; if (to || r !== 2'b00) begin errors++; $display("FAIL s3_pre_bresp: got %b want 00 (timeout=%0b)", r, to); end
      do_write(32'h40, 32'hFFFFFFFF, 4'hF, r, to);
      checks++; if (to || r !== 2'b10) begin errors++; $display("FAIL s3_bresp: got %b want 10 (timeout=%0b)", r, to); end
      do_read(32'h40, d, r, to);
      checks++; if (to || d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL s3_read_oor: got %h/%b want 00000000/10 (timeout=%0b)", d, r, to); end
      do_read(32'h0, d, r, to);
      checks++; if (to || d !== 32'h00000001) begin errors++; $display("FAIL s3_reg0: got %h want 00000001", d); end
      do_read(32'h4, d, r, to);
      checks++; if (to || d !== 32'hDEADBEEF) begin errors++; $display("FAIL s3_reg1: got %h want deadbeef", d); end
      do_read(32'h8, d, r, to);
      checks++; if (to || d !== 32'h112233AA) begin errors++; $display("FAIL s3_reg2: got %h want 112233aa", d); end
   endtask

   task automatic test_bready_stall();
      logic [31:0] d; logic [1:0] r; bit to;
      S_AXI_AWADDR = 32'hC; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
            errors++; $display("FAIL s4_stall%0d: got b=%b resp=%b aw=%b w=%b want 1 00 0 0", i, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY); end
         tick();
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      checks++; if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL s4_b_done: got b=%b aw=%b want 0 1", S_AXI_BVALID, S_AXI_AWREADY); end
      tick();
      S_AXI_AWVALID = 1'b0;
      checks++; if (S_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL s4_aw2_taken: got %b want 0", S_AXI_AWREADY); end
      S_AXI_WDATA = 32'h66; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      tick();
      checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL s4_b2: got %b/%b want 1/00", S_AXI_BVALID, S_AXI_BRESP); end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      do_read(32'hC, d, r, to);
      checks++; if (to || d !== 32'h66) begin errors++; $display("FAIL s4_read: got %h want 00000066", d); end
   endtask

   task automatic test_write_read_collision();
      logic [31:0] d; logic [1:0] r; bit to;
      S_AXI_AWADDR = 32'h0; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1) begin errors++; $display("FAIL s5_valids: got b=%b r=%b want 1 1", S_AXI_BVALID, S_AXI_RVALID); end
      checks++; if (S_AXI_RDATA !== 32'h1 || S_AXI_RRESP !== 2'b00) begin errors++; $display("FAIL s5_old: got %h/%b want 00000001/00", S_AXI_RDATA, S_AXI_RRESP); end
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      do_read(32'h0, d, r, to);
      checks++; if (to || d !== 32'h5) begin errors++; $display("FAIL s5_new: got %h want 00000005", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; bit to;
      S_AXI_AWADDR = 32'h4; S_AXI_AWVALID = 1'b1;
      S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      checks++; if (S_AXI_RVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL s6_pre: got r=%b aw=%b want 1 0", S_AXI_RVALID, S_AXI_AWREADY); end
      #2;
      ARESETN = 1'b0;
      #1;
      checks++; if (S_AXI_RVALID !== 1'b0 || S_AXI_BVALID !== 1'b0 || S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00) begin
         errors++; $display("FAIL s6_async: got r=%b b=%b rdata=%h rresp=%b bresp=%b want 0 0 0 00 00", S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP); end
      @(negedge ACLK);
      ARESETN = 1'b1;
      tick();
      checks++; if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
         errors++; $display("FAIL s6_readies: got aw=%b w=%b ar=%b want 1 1 1", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY); end
      S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      tick();
      checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL s6_stale_aw: got bvalid %b want 0", S_AXI_BVALID); end
      S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      tick();
      checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL s6_b: got %b/%b want 1/00", S_AXI_BVALID, S_AXI_BRESP); end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      do_read(32'h4, d, r, to);
      checks++; if (to || d !== 32'h0) begin errors++; $display("FAIL s6_reg1_cleared: got %h want 00000000", d); end
      do_read(32'h8, d, r, to);
      checks++; if (to || d !== 32'h77) begin errors++; $display("FAIL s6_reg2: got %h want 00000077", d); end
   endtask

   initial begin
      ARESETN = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      test_reset();
      test_same_cycle_write();
      test_w_before_aw();
      test_out_of_range();
      test_bready_stall();
      test_write_read_collision();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
